// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - drains a RAM address window into a valid/ready stream
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  read_req,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  req_last;
    logic                  pend;
    logic                  pend_last;

    logic [DATA_WIDTH-1:0] fifo_data [4];
    logic [3:0]            fifo_last;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_count;

    logic                  pop;
    logic [2:0]            occupancy;
    logic                  can_issue;

    assign m_valid   = (fifo_count != 3'd0);
    assign m_data    = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_last    = m_valid & fifo_last[rd_ptr];
    assign pop       = m_valid & m_ready;

    // Only registered terms, so m_ready never reaches read_req combinationally.
    // The read issued this cycle is not counted, which bounds occupancy at 4.
    assign occupancy = fifo_count + {2'b00, pend};
    assign can_issue = (remaining != '0) && (occupancy <= 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            read_req  <= 1'b0;
            read_addr <= '0;
            addr_cnt  <= '0;
            remaining <= '0;
            req_last  <= 1'b0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            done      <= 1'b0;
            read_req  <= 1'b0;
            pend      <= read_req;
            pend_last <= req_last;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state     <= FETCH;
                            busy      <= 1'b1;
                            read_req  <= 1'b1;
                            read_addr <= base_addr;
                            addr_cnt  <= base_addr + 1'b1;
                            remaining <= length - 1'b1;
                            req_last  <= (length == (ADDR_WIDTH+1)'(1));
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (remaining == '0) begin
                        state <= DRAIN;
                    end else if (can_issue) begin
                        read_req  <= 1'b1;
                        read_addr <= addr_cnt;
                        addr_cnt  <= addr_cnt + 1'b1;
                        remaining <= remaining - 1'b1;
                        req_last  <= (remaining == (ADDR_WIDTH+1)'(1));
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_last  <= '0;
        end else begin
            if (pend) begin
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({pend, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Payload storage needs no reset; m_data is gated by m_valid.
    always_ff @(posedge clk) begin
        if (pend) begin
            fifo_data[wr_ptr] <= read_data;
        end
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Sequencer that drains a contiguous address window of a synchronous-read `ram` (read register enabled, 1-cycle read latency) into a valid/ready stream. It sits between a data RAM and a consumer such as a PE-array feeder. It issues `read_req`/`read_addr`, captures `read_data` into a 4-entry output FIFO, and absorbs consumer backpressure without losing or duplicating words. There is no combinational path from `m_ready` to `read_req`.

## Interface
- DATA_WIDTH, 8, word width; matches the RAM.
- ADDR_WIDTH, 12, RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a transfer; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address; sampled with start.
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer completion.
- read_req  out  1  RAM read enable; registered.
- read_addr  out  ADDR_WIDTH  RAM read address; registered.
- read_data  in  DATA_WIDTH  signed RAM data; valid the cycle after read_req.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  consumer accepts the beat.
- m_data  out  DATA_WIDTH  beat payload, bit-identical to read_data.
- m_last  out  1  marks beat index length-1.

## Operation
- FSM states:
  - IDLE: start=1 with length>0 → FETCH; start=1 with length=0 → stays IDLE and pulses done the next cycle. busy=0.
  - FETCH: issues reads until remaining=0, then → DRAIN.
  - DRAIN: waits for the handshake on the m_last beat, then → IDLE.
- start is ignored outside IDLE.
- Counters:
  - addr_cnt loads base_addr and increments by 1 per issued read, wrapping at 2^ADDR_WIDTH.
  - remaining loads length and decrements per issue.
- Issue rule (FETCH only): read_req=1 next cycle iff remaining>0 and fifo_count + pend ≤ 2.
  - pend = read_req registered one cycle, i.e. a word currently on read_data.
  - The rule uses registered terms only.
- Capture: when pend=1, read_data is pushed into the FIFO at the clock edge, tagged last when it is word length-1.
- Overflow is impossible: worst case occupancy is 4.
- FIFO: depth 4, first-word-fall-through.
  - m_valid = (fifo_count>0); m_data/m_last show the head entry.
  - Pop on m_valid & m_ready. Push and pop may occur in the same cycle; count is then unchanged.
- Completion: on the handshake of the m_last beat, the next cycle has done=1 and busy=0.
- busy is 1 from the cycle after start is sampled through the cycle of that handshake.
- reset (at any time, including mid-transfer):
  - FSM → IDLE; counters, FIFO and pend are cleared.
  - In-flight RAM data is discarded.
  - No done pulse is generated for the aborted transfer.
- Reset values: busy=0, done=0, read_req=0, read_addr=0, m_valid=0, m_data=0, m_last=0.
- When m_valid=0, m_data and m_last are held at 0.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycle 1: busy=1, read_req=1, read_addr=base_addr.
- Cycle 2: read_data = mem[base_addr]; pushed at the end of cycle 2.
- Cycle 3: m_valid=1 with the first word. Start-to-first-beat latency is 3 cycles.
- Steady state with m_ready held 1: one read issued and one beat delivered per cycle.
  - Length N with no stall: beats in cycles 3..N+2, m_last in cycle N+2, done in cycle N+3.
- Stall (m_ready=0): issue stops once fifo_count + pend reaches 3.
  - Issue resumes the cycle after a pop brings that sum to ≤2.
  - No beat is lost, duplicated or reordered.
- m_valid, once asserted, stays asserted with stable m_data/m_last until the handshake.
- length=0: start in cycle 0 → done=1 in cycle 1; busy, read_req and m_valid stay 0.

## Test plan
- RAM preloaded mem[a]=a; base=10, length=4, m_ready=1:
  - read_addr 10..13 in cycles 1..4.
  - Beats 10,11,12,13 in cycles 3..6, m_last only in cycle 6.
  - done in cycle 7; busy 1 in cycles 1..6.
- Same transfer, m_ready=0 during cycles 3..10:
  - read_req stops after 4 issues; FIFO holds 4 words.
  - m_valid held with data 10 through the stall.
  - Beats 10..13 complete in order after release; done exactly once.
- ADDR_WIDTH=12, base=4094, length=4: read_addr sequence 4094, 4095, 0, 1; beats match.
- length=0: done pulse in cycle 1; no read_req, no m_valid, busy=0 throughout.
- length=8, reset asserted in cycle 5:
  - All outputs 0 the next cycle; no done pulse.
  - A new start (base=0, length=2) yields beats 0 and 1 only.
- length=3: start pulsed again in cycles 2 and 4 is ignored; exactly 3 beats and one done.
- Negative data: mem[5]=-1 (0xFF), base=5, length=1 → m_data=0xFF.
